// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Multi-cycle sequencer for the 16-bit CPU datapath. Each instruction is
// stepped through FETCH, DECODE, EXEC, MEM and WB. The block drives the
// datapath control strobes, the PC/IR load strobes and the shared memory-port
// handshake. A memory wait that lasts too long parks the sequencer in a
// sticky FAULT state that only Reset leaves.
//
// Parameters:
//   TIMEOUT_CYCLES  max consecutive MemReady wait cycles in FETCH/MEM that are
//                   tolerated before FAULT (0 disables the timeout)
//
// Ports:
//   Clock      in   system clock, rising edge
//   Reset      in   synchronous, active-high reset
//   Enable     in   run request, sampled in IDLE and at instruction retire
//   OPCODE     in   IR[15:13], latched in DECODE
//   MemReady   in   memory accepted/completed the current request
//   Zero       in   ALU zero flag (BNE condition)
//   PCWrite    out  PC load (FETCH completion or BNE taken)
//   PCSrc      out  0 = ALU result (PC+2), 1 = ALUOut (branch target)
//   IorD       out  memory address select: 0 = PC, 1 = ALUOut
//   IRWrite    out  load IR from memory data
//   MemRead    out  memory read request
//   MemWrite   out  memory write request
//   MemToReg   out  write-back source: 1 = MDR
//   RegDst     out  1 = rd field, 0 = rt field
//   RegWrite   out  register file write
//   ALUSrcA    out  0 = PC, 1 = rs
//   ALUSrcB    out  00 rt, 01 const 2, 10 sign-ext imm, 11 branch offset
//   ALUOp      out  00 add, 01 sub/compare, 10 funct, 11 immediate op
//   State      out  current state (debug)
//   InstrDone  out  one-cycle pulse in the retiring cycle
//   Fault      out  sticky memory timeout indication
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [2:0] OPCODE,
    input  logic       MemReady,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] State,
    output logic       InstrDone,
    output logic       Fault
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_FAULT  = 3'd7;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ANDI  = 3'b001;
    localparam logic [2:0] OP_ORI   = 3'b010;
    localparam logic [2:0] OP_ADDI  = 3'b011;
    localparam logic [2:0] OP_SLTI  = 3'b100;
    localparam logic [2:0] OP_LW    = 3'b101;
    localparam logic [2:0] OP_SW    = 3'b110;
    localparam logic [2:0] OP_BNE   = 3'b111;

    // Counter must be at least 4 bits and wide enough to hold TIMEOUT_CYCLES.
    localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW > 4) ? CNT_W_RAW : 4;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

    logic [2:0]       state_r;
    logic [2:0]       state_next_s;
    logic [2:0]       opcode_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             timeout_hit_s;
    logic [2:0]       retire_next_s;
    logic             in_wait_state_s;

    // Timeout fires only when the registered count already sits at the limit
    // and memory is still not ready; a late MemReady at the limit wins.
    assign timeout_hit_s   = (TIMEOUT_CYCLES != 0) && !MemReady && (wait_cnt_r == TIMEOUT_VAL);
    assign retire_next_s   = Enable ? ST_FETCH : ST_IDLE;
    assign in_wait_state_s = (state_r == ST_FETCH) || (state_r == ST_MEM);

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Opcode latch: captured once in DECODE so later IR-bus changes are ignored.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            opcode_r <= 3'b000;
        end else if (state_r == ST_DECODE) begin
            opcode_r <= OPCODE;
        end else begin
            opcode_r <= opcode_r;
        end
    end

    // Memory wait counter: counts consecutive not-ready cycles in FETCH/MEM,
    // clears on completion or any state change, saturates instead of wrapping.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wait_cnt_r <= CNT_ZERO;
        end else if (MemReady || (state_next_s != state_r) || !in_wait_state_s) begin
            wait_cnt_r <= CNT_ZERO;
        end else if (wait_cnt_r != CNT_MAX) begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Enable) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (MemReady) begin
                    state_next_s = ST_DECODE;
                end else if (timeout_hit_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                state_next_s = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode_r)
                    OP_RTYPE, OP_ANDI, OP_ORI, OP_ADDI, OP_SLTI: state_next_s = ST_WB;
                    OP_LW, OP_SW:                                state_next_s = ST_MEM;
                    OP_BNE:                                      state_next_s = retire_next_s;
                    default:                                     state_next_s = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                if (MemReady) begin
                    if (opcode_r == OP_LW) begin
                        state_next_s = ST_WB;
                    end else begin
                        state_next_s = retire_next_s;
                    end
                end else if (timeout_hit_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB: begin
                state_next_s = retire_next_s;
            end
            ST_FAULT: begin
                state_next_s = ST_FAULT;
            end
            default: begin
                // Unused encoding 6: treat as corruption and park safely.
                state_next_s = ST_FAULT;
            end
        endcase
    end

    // Output decode from registered state and latched opcode.
    always_comb begin
        PCWrite   = 1'b0;
        PCSrc     = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemToReg  = 1'b0;
        RegDst    = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        InstrDone = 1'b0;
        Fault     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                PCWrite = 1'b0;
            end
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR and PC+2 are committed only in the cycle memory delivers.
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            ST_DECODE: begin
                ALUSrcB = 2'b11;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                case (opcode_r)
                    OP_RTYPE: begin
                        ALUSrcB = 2'b00;
                        ALUOp   = 2'b10;
                    end
                    OP_ANDI, OP_ORI, OP_ADDI, OP_SLTI: begin
                        ALUSrcB = 2'b10;
                        ALUOp   = 2'b11;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrcB = 2'b10;
                        ALUOp   = 2'b00;
                    end
                    OP_BNE: begin
                        ALUSrcB   = 2'b00;
                        ALUOp     = 2'b01;
                        PCSrc     = 1'b1;
                        PCWrite   = ~Zero;
                        InstrDone = 1'b1;
                    end
                    default: begin
                        ALUSrcA = 1'b0;
                    end
                endcase
            end
            ST_MEM: begin
                IorD      = 1'b1;
                MemRead   = (opcode_r == OP_LW);
                MemWrite  = (opcode_r == OP_SW);
                InstrDone = (opcode_r == OP_SW) && MemReady;
            end
            ST_WB: begin
                RegWrite  = 1'b1;
                RegDst    = (opcode_r == OP_RTYPE);
                MemToReg  = (opcode_r == OP_LW);
                InstrDone = 1'b1;
            end
            ST_FAULT: begin
                Fault = 1'b1;
            end
            default: begin
                Fault = 1'b0;
            end
        endcase
    end

    assign State = state_r;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the 16-bit CPU datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- It drives the same datapath control signals as the single-cycle decoder, plus PC, IR and memory-handshake strobes.
- It sits between instruction/data memory (shared port, ready handshake) and the register file/ALU, and flags a sticky fault on memory timeout.

Parameters:
- TIMEOUT_CYCLES, 15: max consecutive wait cycles on MemReady in FETCH or MEM before FAULT; 0 disables the timeout.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high.
- Enable  input  1  run request; sampled only in IDLE and at instruction retire.
- OPCODE  input  3  IR[15:13]; valid from DECODE onward.
- MemReady  input  1  memory accepted/completed the current MemRead/MemWrite this cycle.
- Zero  input  1  ALU zero flag.
- PCWrite  output  1  PC load: unconditional, or BNE taken.
- PCSrc  output  1  0 = ALU result (PC+2), 1 = ALUOut (branch target).
- IorD  output  1  memory address: 0 = PC, 1 = ALUOut.
- IRWrite  output  1  load IR from memory data.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- MemToReg  output  1  write-back source: 1 = MDR.
- RegDst  output  1  1 = rd field, 0 = rt field.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  0 = PC, 1 = rs.
- ALUSrcB  output  2  00 = rt, 01 = constant 2, 10 = sign-extended imm, 11 = branch offset.
- ALUOp  output  2  same encoding as decoder: 00 add, 01 sub/compare, 10 funct, 11 immediate op.
- State  output  3  current state, for debug.
- InstrDone  output  1  one-cycle pulse in the retiring cycle.
- Fault  output  1  sticky memory timeout.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7.
- Reset is synchronous: the next edge forces IDLE, clears the wait counter and the latched opcode, and clears Fault. All outputs are 0 while State=IDLE, except State=0.
- Reset has priority over every other event, including mid-handshake. Memory requests drop the cycle after the Reset edge.
- Outputs decode combinationally from the registered state and the latched opcode. PCWrite and IRWrite additionally depend on MemReady/Zero as noted below.
- IDLE: Enable=1 -> FETCH.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - Holds until MemReady=1. In that cycle IRWrite=1 and PCWrite=1 (PCSrc=0), then -> DECODE.
- DECODE: latch OPCODE; ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut); -> EXEC.
- EXEC, by latched opcode:
  - 000 (R-type): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB.
  - 001/010/011/100 (ANDI/ORI/ADDI/SLTI): ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> WB.
  - 101/110 (LW/SW): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM.
  - 111 (BNE): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=~Zero; retire.
- MEM:
  - IorD=1. LW asserts MemRead; SW asserts MemWrite.
  - Each request is held until MemReady=1. Then LW -> WB; SW retires.
- WB: RegWrite=1; RegDst=1 only for 000; MemToReg=1 only for LW; retire.
- Retire: InstrDone=1 for that cycle. Next state is FETCH if Enable=1, else IDLE. Enable falling mid-instruction never aborts the instruction.
- Latency with zero-wait memory (MemReady=1 at first request cycle):
  - R/I-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BNE: 3 cycles.
  - Each wait cycle adds 1.
- Wait counter:
  - 4-bit minimum width; must hold TIMEOUT_CYCLES.
  - Increments each FETCH/MEM cycle with MemReady=0; clears on MemReady=1 and on any state change.
  - When the count equals TIMEOUT_CYCLES with MemReady still 0 (and TIMEOUT_CYCLES≠0): next state FAULT, no strobe.
  - MemReady=1 in the same cycle the count reaches the limit: the transfer completes and no fault occurs.
- FAULT: Fault=1, all other strobes 0, State=7. Leaves only on Reset.
- An opcode change on OPCODE after DECODE is ignored; the latched value is used.

Test Plan:
- Reset, Enable=1, MemReady=1, OPCODE=000 -> states 0,1,2,3,5,1. RegWrite=1 and RegDst=1 in WB. InstrDone pulses at cycle 4 after leaving IDLE.
- OPCODE=101, MemReady low 3 cycles in MEM -> MemRead and IorD=1 held 4 cycles. WB has MemToReg=1, RegWrite=1. Total 8 cycles.
- OPCODE=111 with Zero=0 -> PCWrite=1, PCSrc=1 in EXEC. Repeat with Zero=1 -> PCWrite=0. Both retire in 3 cycles.
- TIMEOUT_CYCLES=15, MemReady stuck 0 in FETCH -> FAULT entered after 15 wait cycles, Fault=1. Fault persists; cleared only by the Reset edge, which returns to IDLE.
- Reset asserted while SW is in MEM with MemWrite=1 -> next cycle MemWrite=0, State=0, no InstrDone.
- Enable dropped during EXEC of ADDI (011) -> WB completes with RegWrite=1 and ALUSrcB=10 in EXEC. InstrDone pulses, then IDLE. Re-asserting Enable -> FETCH next cycle.
